// File: rtl/heroe_pkg.sv
// Shared definitions for the obstacle game: top-level game state encodings,
// W_or_L verdict codes, player pose encodings and small helpers.
package heroe_pkg;

    // Top-level game state machine encodings (as seen on `presente`)
    typedef enum logic [2:0] {
        OFF  = 3'd0,
        WLCM = 3'd1,
        CH   = 3'd2,
        GAME = 3'd3,
        WL   = 3'd4,
        PA   = 3'd5
    } estado_juego_t;

    // W_or_L output codes
    localparam logic [1:0] WL_JUEGO  = 2'b00;
    localparam logic [1:0] WL_GANA   = 2'b10;
    localparam logic [1:0] WL_PIERDE = 2'b01;

    // Verdict FSM states share the W_or_L codes so the output is the state itself
    typedef enum logic [1:0] {
        JUEGO  = WL_JUEGO,
        GANA   = WL_GANA,
        PIERDE = WL_PIERDE
    } veredicto_t;

    // Player pose, also the encoding driven on `jugador`
    typedef enum logic [1:0] {
        SUELO    = 2'd0,
        SALTO    = 2'd1,
        AGACHADO = 2'd2
    } pose_t;

    // Starting lives when the lives feature is built
    localparam logic [1:0] VIDAS_INI = 2'd3;

    // Saturating 8-bit increment used by the score counter
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop sampler of a slow square wave plus rising-edge pulse.
// The input is treated as data; `flanco` is high for exactly one clk cycle
// per rising edge of `entrada`.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic flanco
);

    logic q1;
    logic q2;

    // Sample the input twice so the edge is detected on settled data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= entrada;
            q2 <= q1;
        end
    end

    assign flanco = q1 & ~q2;

endmodule

// File: rtl/detector_colisiones.sv
// Collision detector: follows the obstacle display one tick at a time,
// tracks the player's jump/duck pose and produces score and win/lose verdict.
// Optional feature: define DETECTOR_VIDAS_EN to build the lives counter.
module detector_colisiones
    import heroe_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE  = 8'd20,
    parameter logic [3:0] JUMP_TICKS = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_obstaculos,
    input  logic [2:0]  presente,
    input  logic [20:0] display_obs,
    input  logic [3:0]  tipo_obs,
    input  logic        btn_salto,
    input  logic        btn_agacharse,
    output logic [1:0]  W_or_L,
    output logic [7:0]  score,
    output logic [1:0]  vidas,
    output logic [1:0]  jugador
);

    logic       tick;
    logic       en_juego;
    logic       activo;
    logic [3:0] tipo_col [3];
    logic [3:0] tipo_actual;
    pose_t      pose;
    logic [3:0] pose_cnt;
    veredicto_t veredicto;
    logic [7:0] score_reg;
    logic [7:0] score_inc;
    logic       hay_obs;
    logic       acierto;
    logic       choque;
    logic       libra;
    logic       pierde_now;
    logic       gana_now;
    logic       unused_bits;

    detector_flanco u_flanco (
        .clk     (clk),
        .rst_n   (rst_n),
        .entrada (clk_obstaculos),
        .flanco  (tick)
    );

    assign en_juego = (presente == GAME);
    assign activo   = en_juego && (veredicto == JUEGO);

    // Column-type pipeline: shifts with the display on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) tipo_col[i] <= '0;
        end else if (!en_juego) begin
            for (int i = 0; i < 3; i++) tipo_col[i] <= '0;
        end else if (activo && tick) begin
            tipo_col[0] <= tipo_col[1];
            tipo_col[1] <= tipo_col[2];
            tipo_col[2] <= tipo_obs;
        end
    end

    // On a tick the display has already shifted, so the obstacle now in
    // column 0 is the one whose type is moving into tipo_col[0] this cycle.
    assign tipo_actual = tick ? tipo_col[1] : tipo_col[0];
    assign hay_obs     = (display_obs[6:0] != 7'd0);
    assign acierto     = tipo_actual[0] ? (pose == AGACHADO) : (pose == SALTO);
    assign choque      = activo && tick && hay_obs && !acierto;
    assign libra       = activo && tick && hay_obs && acierto;
    assign score_inc   = sat_inc(score_reg);
    assign gana_now    = libra && (score_inc == WIN_SCORE);

    // Player pose FSM: a press starts a jump/duck lasting JUMP_TICKS ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pose     <= SUELO;
            pose_cnt <= '0;
        end else if (!en_juego) begin
            pose     <= SUELO;
            pose_cnt <= '0;
        end else if (veredicto == JUEGO) begin
            case (pose)
                SUELO: begin
                    if (btn_salto) begin
                        pose     <= SALTO;
                        pose_cnt <= JUMP_TICKS;
                    end else if (btn_agacharse) begin
                        pose     <= AGACHADO;
                        pose_cnt <= JUMP_TICKS;
                    end
                end
                SALTO, AGACHADO: begin
                    if (tick) begin
                        if (pose_cnt <= 4'd1) begin
                            pose     <= SUELO;
                            pose_cnt <= '0;
                        end else begin
                            pose_cnt <= pose_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    pose     <= SUELO;
                    pose_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DETECTOR_VIDAS_EN
    logic [1:0] vidas_reg;

    // Lives counter: each collision costs one life, the last one ends the game
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vidas_reg <= VIDAS_INI;
        end else if (!en_juego) begin
            vidas_reg <= VIDAS_INI;
        end else if (choque && vidas_reg != 2'd0) begin
            vidas_reg <= vidas_reg - 2'd1;
        end
    end

    assign pierde_now = choque && (vidas_reg == 2'd1);
    assign vidas      = vidas_reg;
`else
    assign pierde_now = choque;
    assign vidas      = 2'b00;
`endif

    // Verdict FSM and score: score counts cleared obstacles, verdict latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            veredicto <= JUEGO;
            score_reg <= '0;
        end else if (!en_juego) begin
            veredicto <= JUEGO;
            score_reg <= '0;
        end else if (veredicto == JUEGO) begin
            if (libra) begin
                score_reg <= score_inc;
            end
            if (pierde_now) begin
                veredicto <= PIERDE;
            end else if (gana_now) begin
                veredicto <= GANA;
            end
        end
    end

    assign W_or_L  = veredicto;
    assign score   = score_reg;
    assign jugador = pose;

    // Upper display columns and type bits beyond the class bit are not needed here
    assign unused_bits = ^{display_obs[20:7], tipo_actual[3:1]};

endmodule

// File: tb/tb_detector_colisiones.sv
// Randomized and directed bench for detector_colisiones with an
// obstacle-level reference model (columns tracked as obstacle/type pairs).
module tb_detector_colisiones;
    import heroe_pkg::*;

    localparam logic [7:0] WIN = 8'd3;
    localparam int         JT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_obstaculos = 1'b0;
    logic [2:0]  presente = 3'd0;
    logic [20:0] display_obs = '0;
    logic [3:0]  tipo_obs = '0;
    logic        btn_salto = 1'b0;
    logic        btn_agacharse = 1'b0;
    logic [1:0]  W_or_L;
    logic [7:0]  score;
    logic [1:0]  vidas;
    logic [1:0]  jugador;

    int total = 0;
    int bad = 0;

    // Reference model: obstacle pattern and type per column, plus game state
    logic [6:0] m_pat [3];
    logic [3:0] m_typ [3];
    int m_score, m_wl, m_vidas, m_pose, m_left;

    detector_colisiones #(.WIN_SCORE(WIN), .JUMP_TICKS(4'(JT))) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_obstaculos (clk_obstaculos),
        .presente       (presente),
        .display_obs    (display_obs),
        .tipo_obs       (tipo_obs),
        .btn_salto      (btn_salto),
        .btn_agacharse  (btn_agacharse),
        .W_or_L         (W_or_L),
        .score          (score),
        .vidas          (vidas),
        .jugador        (jugador)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_pat[i] = '0;
            m_typ[i] = '0;
        end
        m_score = 0;
        m_wl    = 0;
        m_pose  = 0;
        m_left  = 0;
`ifdef DETECTOR_VIDAS_EN
        m_vidas = int'(VIDAS_INI);
`else
        m_vidas = 0;
`endif
    endfunction

    // A press while standing starts a pose lasting JT obstacle ticks
    function automatic void model_press(input logic [1:0] b);
        if (m_wl == 0 && m_pose == 0 && b != 2'b00) begin
            m_pose = b[0] ? 1 : 2;
            m_left = JT;
        end
    endfunction

    // One obstacle step: judge column 0 with the pose held before this tick
    function automatic void model_tick();
        int need;
        if (m_wl != 0) return;
        if (m_pat[0] != 7'd0) begin
            need = m_typ[0][0] ? 2 : 1;
            if (m_pose == need) begin
                if (m_score < 255) m_score = m_score + 1;
                if (m_score == int'(WIN)) m_wl = 2;
            end else begin
`ifdef DETECTOR_VIDAS_EN
                m_vidas = m_vidas - 1;
                if (m_vidas == 0) m_wl = 1;
`else
                m_wl = 1;
`endif
            end
        end
        if (m_pose != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_pose = 0;
        end
    endfunction

    // Generator stand-in: low phase, optional one-clk button pulse, rising edge
    // with the new obstacle in column 2; returns once the tick has been consumed.
    task automatic obs_step(input logic [6:0] pat, input logic [3:0] typ, input logic [1:0] btn);
        @(negedge clk);
        clk_obstaculos = 1'b0;
        repeat (3) @(negedge clk);
        if (btn != 2'b00) begin
            btn_salto     = btn[0];
            btn_agacharse = btn[1];
            model_press(btn);
            @(negedge clk);
            btn_salto     = 1'b0;
            btn_agacharse = 1'b0;
        end
        clk_obstaculos = 1'b1;
        display_obs    = {pat, display_obs[20:7]};
        tipo_obs       = typ;
        m_pat[0] = m_pat[1]; m_pat[1] = m_pat[2]; m_pat[2] = pat;
        m_typ[0] = m_typ[1]; m_typ[1] = m_typ[2]; m_typ[2] = typ;
        repeat (2) @(negedge clk);
        model_tick();
    endtask

    task automatic start_game();
        @(negedge clk);
        presente    = 3'(GAME);
        display_obs = '0;
        tipo_obs    = '0;
        model_clear();
    endtask

    task automatic leave_game();
        @(negedge clk);
        presente    = 3'(WLCM);
        display_obs = '0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        presente = 3'(WLCM);
        model_clear();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            clk_obstaculos = 1'b1;
            repeat (4) begin @(negedge clk); n += int'(dut.tick); end
            clk_obstaculos = 1'b0;
            repeat (4) begin @(negedge clk); n += int'(dut.tick); end
        end
        total++; if (n !== 0) begin bad++; $display("FAIL reset_tick_held: got %0d expected 0", n); end
        total++; if (W_or_L !== 2'b00) begin bad++; $display("FAIL reset_wl: got %b expected 00", W_or_L); end
        total++; if (score !== 8'd0) begin bad++; $display("FAIL reset_score: got %0d expected 0", score); end
        total++; if (jugador !== 2'd0) begin bad++; $display("FAIL reset_jugador: got %0d expected 0", jugador); end
        total++; if (vidas !== 2'(m_vidas)) begin bad++; $display("FAIL reset_vidas: got %0d expected %0d", vidas, m_vidas); end
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            clk_obstaculos = 1'b1;
            n = 0;
            repeat (6) begin @(negedge clk); n += int'(dut.tick); end
            total++; if (n !== 1) begin bad++; $display("FAIL tick_width edge %0d: got %0d cycles expected 1", e, n); end
            clk_obstaculos = 1'b0;
            repeat (4) @(negedge clk);
        end
        total++; if (W_or_L !== 2'b00 || score !== 8'd0 || jugador !== 2'd0) begin
            bad++; $display("FAIL idle_outputs: got wl=%b score=%0d jug=%0d expected 00/0/0", W_or_L, score, jugador);
        end
    endtask

    task automatic test_salto();
        start_game();
        obs_step(7'h1C, 4'd2, 2'b00);
        obs_step(7'h00, 4'd0, 2'b01);
        obs_step(7'h00, 4'd0, 2'b00);
        total++; if (score !== 8'd1) begin bad++; $display("FAIL salto_score: got %0d expected 1", score); end
        total++; if (W_or_L !== 2'b00) begin bad++; $display("FAIL salto_wl: got %b expected 00", W_or_L); end
        total++; if (jugador !== 2'd0) begin bad++; $display("FAIL salto_jugador: got %0d expected 0", jugador); end
    endtask

    task automatic test_aereo();
        leave_game();
        start_game();
        obs_step(7'h08, 4'd1, 2'b00);
        obs_step(7'h00, 4'd0, 2'b00);
        total++; if (W_or_L !== 2'b00) begin bad++; $display("FAIL aereo_wl_before: got %b expected 00", W_or_L); end
        obs_step(7'h00, 4'd0, 2'b00);
        total++; if (W_or_L !== 2'(m_wl)) begin bad++; $display("FAIL aereo_wl: got %b expected %0d", W_or_L, m_wl); end
        total++; if (vidas !== 2'(m_vidas)) begin bad++; $display("FAIL aereo_vidas: got %0d expected %0d", vidas, m_vidas); end
        for (int i = 0; i < 4; i++) begin
            obs_step((i % 2 == 0) ? 7'h41 : 7'h00, 4'd2, (i % 2 == 1) ? 2'b01 : 2'b00);
            total++; if (score !== 8'(m_score)) begin bad++; $display("FAIL aereo_frozen_score step %0d: got %0d expected %0d", i, score, m_score); end
        end
    endtask

    task automatic test_gana();
        leave_game();
        start_game();
        for (int i = 0; i < 7; i++) begin
            obs_step((i % 2 == 0 && i < 5) ? 7'h22 : 7'h00, 4'd4, (i % 2 == 1) ? 2'b01 : 2'b00);
        end
        total++; if (score !== 8'd3) begin bad++; $display("FAIL gana_score: got %0d expected 3", score); end
        total++; if (W_or_L !== 2'b10) begin bad++; $display("FAIL gana_wl: got %b expected 10", W_or_L); end
        leave_game();
        total++; if (W_or_L !== 2'b00 || score !== 8'd0 || jugador !== 2'd0) begin
            bad++; $display("FAIL gana_clear: got wl=%b score=%0d jug=%0d expected 00/0/0", W_or_L, score, jugador);
        end
        total++; if (vidas !== 2'(m_vidas)) begin bad++; $display("FAIL gana_clear_vidas: got %0d expected %0d", vidas, m_vidas); end
    endtask

    task automatic test_ambos();
        start_game();
        @(negedge clk);
        btn_salto = 1'b1;
        btn_agacharse = 1'b1;
        model_press(2'b11);
        @(negedge clk);
        btn_salto = 1'b0;
        btn_agacharse = 1'b0;
        total++; if (jugador !== 2'd1) begin bad++; $display("FAIL ambos_press: got %0d expected 1", jugador); end
        obs_step(7'h00, 4'd0, 2'b00);
        total++; if (jugador !== 2'd1) begin bad++; $display("FAIL ambos_tick1: got %0d expected 1", jugador); end
        obs_step(7'h00, 4'd0, 2'b00);
        total++; if (jugador !== 2'd0) begin bad++; $display("FAIL ambos_tick2: got %0d expected 0", jugador); end
    endtask

    task automatic test_vidas();
        leave_game();
        start_game();
        for (int k = 0; k < 3; k++) begin
            obs_step(7'h10, 4'd3, 2'b00);
            obs_step(7'h00, 4'd0, 2'b00);
            obs_step(7'h00, 4'd0, 2'b00);
            total++; if (vidas !== 2'(m_vidas)) begin bad++; $display("FAIL vidas_count hit %0d: got %0d expected %0d", k, vidas, m_vidas); end
            total++; if (W_or_L !== 2'(m_wl)) begin bad++; $display("FAIL vidas_wl hit %0d: got %b expected %0d", k, W_or_L, m_wl); end
        end
    endtask

    task automatic test_async_reset();
        leave_game();
        start_game();
        obs_step(7'h05, 4'd6, 2'b00);
        obs_step(7'h00, 4'd0, 2'b01);
        obs_step(7'h00, 4'd0, 2'b00);
        total++; if (score !== 8'd1) begin bad++; $display("FAIL async_pre_score: got %0d expected 1", score); end
        @(negedge clk);
        btn_agacharse = 1'b1;
        @(negedge clk);
        btn_agacharse = 1'b0;
        clk_obstaculos = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        total++; if (score !== 8'd0 || jugador !== 2'd0 || W_or_L !== 2'b00) begin
            bad++; $display("FAIL async_clear: got score=%0d jug=%0d wl=%b expected 0/0/00", score, jugador, W_or_L);
        end
        total++; if (vidas !== 2'(m_vidas)) begin bad++; $display("FAIL async_vidas: got %0d expected %0d", vidas, m_vidas); end
        display_obs = '0;
        tipo_obs = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aleatorio();
        logic [6:0] pat;
        logic [1:0] btn;
        start_game();
        for (int i = 0; i < 90; i++) begin
            pat = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
            btn = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            obs_step(pat, 4'($urandom), btn);
            total++; if (score !== 8'(m_score)) begin bad++; $display("FAIL rnd_score step %0d: got %0d expected %0d", i, score, m_score); end
            total++; if (W_or_L !== 2'(m_wl)) begin bad++; $display("FAIL rnd_wl step %0d: got %b expected %0d", i, W_or_L, m_wl); end
            total++; if (jugador !== 2'(m_pose)) begin bad++; $display("FAIL rnd_jugador step %0d: got %0d expected %0d", i, jugador, m_pose); end
            total++; if (vidas !== 2'(m_vidas)) begin bad++; $display("FAIL rnd_vidas step %0d: got %0d expected %0d", i, vidas, m_vidas); end
            $display("step %0d pat=%h score=%0d wl=%b jug=%0d vidas=%0d", i, pat, score, W_or_L, jugador, vidas);
            if (m_wl != 0) begin
                leave_game();
                start_game();
            end
        end
    endtask

    initial begin
        test_reset();
        test_salto();
        test_aereo();
        test_gana();
        test_ambos();
        test_vidas();
        test_async_reset();
        test_aleatorio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
